// File: rtl/gray_diff_sequencer.sv
// Sweeps all 2^GC_LEN Gray codes under valid/ready handshake, tagging each
// pattern with a one-hot select of the bit that flipped relative to the last.
module gray_diff_sequencer #(
  parameter int GC_LEN     = 2,
  parameter int SEL_LENGTH = GC_LEN + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_start,
  input  logic                  in_abort,
  input  logic                  in_ready,
  output logic                  out_valid,
  output logic [GC_LEN-1:0]     out_GC,
  output logic [SEL_LENGTH-1:0] out_sel_TP,
  output logic                  out_last,
  output logic                  out_busy
);

  localparam logic [0:0]        S_IDLE = 1'b0;
  localparam logic [0:0]        S_RUN  = 1'b1;
  localparam logic [GC_LEN-1:0] N_MAX  = '1;

  logic [0:0]        state_q, state_d;
  logic [GC_LEN-1:0] n_q, n_d;
  logic              run;
  logic [GC_LEN-1:0] low_bit;
  logic [GC_LEN:0]   sel_w;

  assign run = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    if (in_abort) begin
      state_d = S_IDLE;
      n_d     = '0;
    end else if (!run) begin
      if (in_start) begin
        state_d = S_RUN;
        n_d     = '0;
      end
    end else if (in_ready) begin
      if (n_q == N_MAX) begin
        state_d = S_IDLE;
        n_d     = '0;
      end else begin
        n_d = n_q + GC_LEN'(1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
    end
  end

  // Incrementing n flips Gray bit ctz(n): isolate n's lowest set bit and
  // shift it up one slot, with slot 0 reserved for the initial pattern.
  assign low_bit = n_q & (~n_q + GC_LEN'(1'b1));
  assign sel_w   = run ? {low_bit, (n_q == '0)} : '0;

  assign out_valid  = run;
  assign out_busy   = run;
  assign out_GC     = run ? (n_q ^ (n_q >> 1)) : '0;
  assign out_sel_TP = SEL_LENGTH'(sel_w);
  assign out_last   = run && (n_q == N_MAX);

endmodule

// File: tb/tb_gray_diff_sequencer.sv
// Directed and random checks of two sequencer widths against a
// pattern-index reference model.
module tb_gray_diff_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [1:0] st, ab, rd;
  logic       v2, l2, b2;
  logic [1:0] g2;
  logic [2:0] s2;
  logic       v3, l3, b3;
  logic [2:0] g3;
  logic [3:0] s3;

  int errors = 0;
  int checks = 0;
  int mk[2];
  bit mr[2];
  int t2g[4] = '{0, 1, 3, 2};
  int t2s[4] = '{1, 2, 4, 2};
  int t3g[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int t3i[8] = '{0, 1, 2, 1, 3, 1, 2, 1};

  gray_diff_sequencer #(.GC_LEN(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_start(st[0]), .in_abort(ab[0]), .in_ready(rd[0]),
    .out_valid(v2), .out_GC(g2), .out_sel_TP(s2), .out_last(l2), .out_busy(b2));

  gray_diff_sequencer #(.GC_LEN(3)) dut3 (
    .clk(clk), .rstn(rstn), .in_start(st[1]), .in_abort(ab[1]), .in_ready(rd[1]),
    .out_valid(v3), .out_GC(g3), .out_sel_TP(s3), .out_last(l3), .out_busy(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input int k);
    return k ^ (k >> 1);
  endfunction

  // Select derived from which Gray bit actually differs from the previous code.
  function automatic int esel(input int k);
    int d;
    if (k == 0) return 1;
    d = gray(k) ^ gray(k - 1);
    for (int b = 0; b < 16; b++) if (d[b]) return 1 << (b + 1);
    return 0;
  endfunction

  task automatic chk_inst(input int i, input string nm, input logic [31:0] v, gc, sel, last, busy);
    int len;
    len = (i == 0) ? 2 : 3;
    chk({nm, ".valid"}, v,    32'(mr[i]));
    chk({nm, ".busy"},  busy, 32'(mr[i]));
    chk({nm, ".gc"},    gc,   mr[i] ? 32'(gray(mk[i])) : 32'd0);
    chk({nm, ".sel"},   sel,  mr[i] ? 32'(esel(mk[i])) : 32'd0);
    chk({nm, ".last"},  last, 32'(mr[i] && mk[i] == (1 << len) - 1));
  endtask

  task automatic chk_all();
    chk_inst(0, "g2", 32'(v2), 32'(g2), 32'(s2), 32'(l2), 32'(b2));
    chk_inst(1, "g3", 32'(v3), 32'(g3), 32'(s3), 32'(l3), 32'(b3));
  endtask

  task automatic tick();
    int len;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? 2 : 3;
      if (!rstn || ab[i]) begin
        mr[i] = 1'b0; mk[i] = 0;
      end else if (!mr[i]) begin
        if (st[i]) begin mr[i] = 1'b1; mk[i] = 0; end
      end else if (rd[i]) begin
        if (mk[i] == (1 << len) - 1) begin mr[i] = 1'b0; mk[i] = 0; end
        else mk[i]++;
      end
    end
    #1;
    chk_all();
  endtask

  initial begin
    rstn = 1'b0; st = '0; ab = '0; rd = '0;
    mr[0] = 1'b0; mr[1] = 1'b0; mk[0] = 0; mk[1] = 0;
    #12;
    chk_all();
    @(negedge clk) rstn = 1'b1;
    tick();

    // GC_LEN=2 full sweep with ready held high
    rd = 2'b11; st[0] = 1'b1; tick(); st = '0;
    for (int j = 0; j < 4; j++) begin
      chk("req31.gc", 32'(g2), 32'(t2g[j]));
      chk("req31.sel", 32'(s2), 32'(t2s[j]));
      chk("req31.last", 32'(l2), 32'(j == 3));
      tick();
    end
    chk("req31.idle", 32'(v2), 32'd0);

    // GC_LEN=3 full sweep
    st[1] = 1'b1; tick(); st = '0;
    for (int j = 0; j < 8; j++) begin
      chk("req32.gc", 32'(g3), 32'(t3g[j]));
      chk("req32.sel", 32'(s3), 32'(1 << t3i[j]));
      tick();
    end
    chk("req32.idle", 32'(v3), 32'd0);

    // Backpressure at pattern 11
    st[0] = 1'b1; tick(); st = '0; tick(); tick();
    rd[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("req33.hold_gc", 32'(g2), 32'd3);
      chk("req33.hold_sel", 32'(s2), 32'd4);
      if (j < 2) tick();
    end
    rd[0] = 1'b1; tick();
    chk("req33.resume", 32'(g2), 32'd2);
    tick();

    // Abort at the second pattern, then restart
    st[0] = 1'b1; tick(); st = '0; tick();
    ab[0] = 1'b1; tick(); ab = '0;
    chk("req34.valid", 32'(v2), 32'd0);
    chk("req34.busy", 32'(b2), 32'd0);
    st[0] = 1'b1; tick(); st = '0;
    chk("req34.restart", 32'(g2), 32'd0);
    repeat (4) tick();

    // in_start held through the sweep including the final transfer
    st[0] = 1'b1; tick();
    for (int j = 0; j < 4; j++) begin
      chk("req35.gc", 32'(g2), 32'(t2g[j]));
      tick();
    end
    chk("req35.idle", 32'(v2), 32'd0);
    st = '0; tick();

    // Asynchronous reset mid-sweep at pattern 011
    st[1] = 1'b1; tick(); st = '0; tick(); tick();
    chk("req36.at011", 32'(g3), 32'd3);
    #1 rstn = 1'b0;
    #1;
    mr[0] = 1'b0; mr[1] = 1'b0; mk[0] = 0; mk[1] = 0;
    chk("req36.async_valid", 32'(v3), 32'd0);
    chk_all();
    @(negedge clk) rstn = 1'b1;
    repeat (3) tick();

    // Random traffic on both widths
    repeat (400) begin
      st = 2'($urandom) & 2'($urandom);
      ab[0] = ($urandom_range(0, 19) == 0);
      ab[1] = ($urandom_range(0, 19) == 0);
      rd = 2'($urandom) | 2'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
